// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period helper.
// Used by both the transmitter and the receiver on the inter-board link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per serial bit; integer divide, remainder is dropped.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst (async, active-high), push/wr_data write side,
//        pop/rd_data read side (rd_data is the current head, valid when !empty),
//        count (entries held), full, empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small input byte FIFO.
// Ports: clk, rst (async, active-high)
//        in_data/in_valid/in_ready : core-side byte push port
//        tx         : serial line, idle high
//        busy       : frame on the line (START..STOP)
//        frame_done : one-cycle pulse on the last clock of each stop bit
//        fifo_count : bytes waiting, excluding the byte in flight
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  if (CPB < 2) begin : g_cpb_check
    $fatal(1, "uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end

  uart_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n, busy_n, frame_done_n;
  logic             bit_end;
  logic             push, pop;
  logic [7:0]       head;
  logic             fifo_full, fifo_empty;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (cnt == CNT_W'(CPB - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state logic; outputs are looked ahead from the next state so they register cleanly.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n       = (state_n != IDLE);
    frame_done_n = (state_n == STOP) && (cnt_n == CNT_W'(CPB - 1));
  end

  // State and registered outputs; reset drives tx high asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT = 4 (40-clock frames).
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .CLK_HZ     (16),
    .BAUD       (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Expected line level on clock kk (1..40) of a frame carrying b.
  function automatic logic exp_tx(input logic [7:0] b, input int kk);
    int bn;
    bn = (kk - 1) / 4;
    if (bn == 0) return 1'b0;
    if (bn == 9) return 1'b1;
    return b[bn-1];
  endfunction

  // Line decoder: detects the start bit and samples each bit mid-period.
  logic [7:0] dec_q[$];
  logic [7:0] dec_byte;
  int         dec_k = 0;
  bit         dec_active = 1'b0;
  int         dec_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      dec_active = 1'b0;
      dec_k      = 0;
    end else if (!dec_active) begin
      if (tx === 1'b0) begin
        dec_active = 1'b1;
        dec_k      = 1;
      end
    end else begin
      dec_k = dec_k + 1;
      if (dec_k == 2 && tx !== 1'b0) dec_err = dec_err + 1;
      if (dec_k >= 6 && dec_k <= 34 && (dec_k % 4) == 2) dec_byte[(dec_k - 6) / 4] = tx;
      if (dec_k == 38) begin
        if (tx !== 1'b1) dec_err = dec_err + 1;
        else             dec_q.push_back(dec_byte);
      end
      if (dec_k == 40) dec_active = 1'b0;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx got %b exp 1", tx); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", frame_done); end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx cyc %0d got %b exp 1", i, tx); end
    end
  endtask

  task automatic test_single();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", fifo_count); end
    n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL single_pre_tx got %b exp 1", tx); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++; if (tx !== exp_tx(8'hA5, k)) begin n_fail++; $display("FAIL single_tx clk %0d got %b exp %b", k, tx, exp_tx(8'hA5, k)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy clk %0d got %b exp 1", k, busy); end
      n_checks++; if (frame_done !== (k == 40)) begin n_fail++; $display("FAIL single_done clk %0d got %b exp %b", k, frame_done, (k == 40)); end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL single_post_busy got %b exp 0", busy); end
    n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL single_post_tx got %b exp 1", tx); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL single_post_done got %b exp 0", frame_done); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    logic [7:0] cur;
    b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'h55;
    in_data  = b[0];
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count0 got %0d exp 1", fifo_count); end
    in_data = b[1];
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count1 got %0d exp 1", fifo_count); end
        in_data = b[2];
      end
      if (k == 2) begin
        n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count2 got %0d exp 2", fifo_count); end
        in_valid = 1'b0;
      end
      if (k == 41) begin
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_drain1 got %0d exp 1", fifo_count); end
      end
      if (k == 81) begin
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain0 got %0d exp 0", fifo_count); end
      end
      cur = b[(k - 1) / 40];
      n_checks++; if (tx !== exp_tx(cur, (k - 1) % 40 + 1)) begin n_fail++; $display("FAIL b2b_tx clk %0d got %b exp %b", k, tx, exp_tx(cur, (k - 1) % 40 + 1)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy clk %0d got %b exp 1", k, busy); end
      n_checks++; if (frame_done !== ((k % 40) == 0)) begin n_fail++; $display("FAIL b2b_done clk %0d got %b exp %b", k, frame_done, ((k % 40) == 0)); end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_post_busy got %b exp 0", busy); end
    n_checks++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL b2b_post_tx got %b exp 1", tx); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_fifo();
    logic [7:0] d [6];
    int  idx;
    int  cyc;
    int  wait_cyc;
    bit  acc;
    bit  seen_full;
    d[0] = 8'h11; d[1] = 8'h3C; d[2] = 8'hE7; d[3] = 8'h80; d[4] = 8'h01; d[5] = 8'h96;
    dec_q.delete();
    dec_err   = 0;
    idx       = 0;
    cyc       = 0;
    seen_full = 1'b0;
    in_data   = d[0];
    in_valid  = 1'b1;
    while (idx < 6 && cyc < 1000) begin
      acc = in_ready;
      n_checks++; if (in_ready !== (fifo_count != 3'd4)) begin n_fail++; $display("FAIL full_ready cyc %0d got %b count %0d", cyc, in_ready, fifo_count); end
      if (fifo_count == 3'd4) seen_full = 1'b1;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
      if (idx < 6) in_data = d[idx];
      else         in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++; if (idx != 6)          begin n_fail++; $display("FAIL full_pushed got %0d exp 6", idx); end
    n_checks++; if (seen_full !== 1'b1) begin n_fail++; $display("FAIL full_reached got %b exp 1", seen_full); end
    wait_cyc = 0;
    while (dec_q.size() < 6 && wait_cyc < 400) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_checks++; if (dec_q.size() != 6) begin n_fail++; $display("FAIL full_rx_count got %0d exp 6", dec_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < dec_q.size()) begin
        n_checks++; if (dec_q[i] !== d[i]) begin n_fail++; $display("FAIL full_rx_byte %0d got %h exp %h", i, dec_q[i], d[i]); end
      end
    end
    n_checks++; if (dec_err != 0) begin n_fail++; $display("FAIL full_framing got %0d exp 0", dec_err); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_push_pop_same_edge();
    int wait_cyc;
    dec_q.delete();
    dec_err  = 0;
    in_data  = 8'h4B;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_data  = 8'hD2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (38) @(negedge clk);
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL pp_done got %b exp 1", frame_done); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL pp_count_pre got %0d exp 1", fifo_count); end
    in_data  = 8'h7E;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL pp_count_post got %0d exp 1", fifo_count); end
    n_checks++; if (tx !== 1'b0)         begin n_fail++; $display("FAIL pp_start got %b exp 0", tx); end
    wait_cyc = 0;
    while (dec_q.size() < 3 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_checks++; if (dec_q.size() != 3) begin n_fail++; $display("FAIL pp_rx_count got %0d exp 3", dec_q.size()); end
    if (dec_q.size() == 3) begin
      n_checks++; if (dec_q[0] !== 8'h4B) begin n_fail++; $display("FAIL pp_rx0 got %h exp 4b", dec_q[0]); end
      n_checks++; if (dec_q[1] !== 8'hD2) begin n_fail++; $display("FAIL pp_rx1 got %h exp d2", dec_q[1]); end
      n_checks++; if (dec_q[2] !== 8'h7E) begin n_fail++; $display("FAIL pp_rx2 got %h exp 7e", dec_q[2]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int wait_cyc;
    dec_q.delete();
    dec_err  = 0;
    in_data  = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_data  = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    n_checks++; if (tx !== 1'b0)         begin n_fail++; $display("FAIL rmf_bit3 got %b exp 0", tx); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL rmf_count_pre got %0d exp 1", fifo_count); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL rmf_tx_async got %b exp 1", tx); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rmf_count got %0d exp 0", fifo_count); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rmf_busy got %b exp 0", busy); end
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rmf_ready got %b exp 1", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmf_idle cyc %0d got %b exp 1", i, tx); end
    end
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_cyc = 0;
    while (dec_q.size() < 1 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_checks++; if (dec_q.size() != 1) begin n_fail++; $display("FAIL rmf_rx_count got %0d exp 1", dec_q.size()); end
    if (dec_q.size() == 1) begin
      n_checks++; if (dec_q[0] !== 8'h3C) begin n_fail++; $display("FAIL rmf_rx_byte got %h exp 3c", dec_q[0]); end
    end
    n_checks++; if (dec_err != 0) begin n_fail++; $display("FAIL rmf_framing got %0d exp 0", dec_err); end
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmf_final_busy got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_push_pop_same_edge();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
